// File: rtl/interface_pack_pkg.sv
// Shared constants and types for the 10-bit symbol <-> 16-bit word pack/unpack pair.
// Eight symbols fill exactly five words; helpers keep the group phase arithmetic in one place.
package interface_pack_pkg;

   localparam int SYM_W       = 10;
   localparam int WORD_W      = 16;
   localparam int ACC_W       = 26;
   localparam int FILL_W      = 5;
   localparam int PHASE_W     = 3;
   localparam int GROUP_SYMS  = 8;
   localparam int GROUP_WORDS = 5;

   typedef logic [SYM_W-1:0]   sym_t;
   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [ACC_W-1:0]   acc_t;
   typedef logic [FILL_W-1:0]  fill_t;
   typedef logic [PHASE_W-1:0] phase_t;

   function automatic phase_t next_phase(input phase_t p);
      return (p == phase_t'(GROUP_WORDS - 1)) ? '0 : p + phase_t'(1);
   endfunction

endpackage

// File: rtl/interface_pack_if.sv
// Symbol-in / word-out bundle of the packer; master is the packer itself, slave is its environment.
interface interface_pack_if;
   import interface_pack_pkg::*;

   sym_t   sym_data;
   logic   sym_valid;
   logic   sym_ready;
   logic   flush;
   word_t  word_data;
   logic   word_valid;
   logic   word_ready;
   phase_t word_phase;
   logic   busy;

   modport master (
      input  sym_data, sym_valid, flush, word_ready,
      output sym_ready, word_data, word_valid, word_phase, busy
   );

   modport slave (
      output sym_data, sym_valid, flush, word_ready,
      input  sym_ready, word_data, word_valid, word_phase, busy
   );

endinterface

// File: rtl/interface_pack_shift.sv
// Masked shift-insert: keeps the low fill_i bits of acc_i and places sym_i directly above them.
// Purely combinational; clearing the bits above fill keeps flush padding zero.
module interface_pack_shift
   import interface_pack_pkg::*;
(
   input  acc_t  acc_i,
   input  fill_t fill_i,
   input  sym_t  sym_i,
   output acc_t  acc_o
);

   acc_t keep_mask;
   acc_t sym_ext;

   always_comb begin
      keep_mask = ~({ACC_W{1'b1}} << fill_i);
      sym_ext   = acc_t'(sym_i) << fill_i;
      acc_o     = (acc_i & keep_mask) | sym_ext;
   end

endmodule

// File: rtl/interface_pack.sv
// Packs 10-bit symbols LSB-first into 16-bit words; one cycle from accepting a symbol to word_valid.
// Stalls symbols when a full word is waiting and not taken; flush zero-pads and emits the tail word.
module interface_pack
   import interface_pack_pkg::*;
(
   input  logic clk,
   input  logic rst,
   interface_pack_if.master bus
);

   localparam fill_t FILL_WORD = fill_t'(WORD_W);
   localparam fill_t FILL_SYM  = fill_t'(SYM_W);

   acc_t   acc_q, acc_d, acc_pop, acc_ins;
   fill_t  fill_q, fill_d, fill_pop;
   logic   flush_pend_q, flush_pend_d;
   phase_t phase_q, phase_d;

   logic word_valid;
   logic sym_ready;
   logic pop;
   logic push;

   // Pop happens before insertion, so the symbol lands above whatever the consumed word left behind.
   interface_pack_shift u_shift (
      .acc_i  (acc_pop),
      .fill_i (fill_pop),
      .sym_i  (bus.sym_data),
      .acc_o  (acc_ins)
   );

   always_comb begin
      word_valid = (fill_q >= FILL_WORD) | (flush_pend_q & (fill_q != '0));
      pop        = word_valid & bus.word_ready;
      sym_ready  = ~flush_pend_q & ((fill_q < FILL_WORD) | pop);
      push       = bus.sym_valid & sym_ready;

      acc_pop  = pop ? (acc_q >> WORD_W) : acc_q;
      fill_pop = fill_q;
      if (pop) begin
         fill_pop = (fill_q >= FILL_WORD) ? fill_q - FILL_WORD : '0;
      end

      acc_d  = push ? acc_ins : acc_pop;
      fill_d = push ? fill_pop + FILL_SYM : fill_pop;

      phase_d      = pop ? next_phase(phase_q) : phase_q;
      flush_pend_d = flush_pend_q;
      if (flush_pend_q) begin
         // Draining done: restart the 5-word group so the unpacker realigns.
         if (fill_d == '0) begin
            flush_pend_d = 1'b0;
            phase_d      = '0;
         end
      end else if (bus.flush) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         phase_q      <= '0;
      end else begin
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         phase_q      <= phase_d;
      end
   end

   assign bus.word_data  = acc_q[WORD_W-1:0];
   assign bus.word_valid = word_valid;
   assign bus.sym_ready  = sym_ready;
   assign bus.word_phase = phase_q;
   assign bus.busy       = (fill_q != '0) | flush_pend_q;

endmodule

// File: tb/tb_interface_pack.sv
// Bench for interface_pack: vector table, stall/flush/reset sequences, and random traffic
// scored against a bit-queue model of the packed stream.
module tb_interface_pack;
   import interface_pack_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   interface_pack_if bus();

   interface_pack dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: stream of accepted bits, expected words, bit count held by the packer.
   bit    mbits[$];
   word_t exp_q[$];
   word_t got_q[$];
   int    mfill;
   bit    mflush;
   int    mcnt;
   bit    chk_en;

   logic   obs_push, obs_pop, obs_busy, obs_valid;
   phase_t obs_phase;
   word_t  obs_data;

   typedef struct {
      sym_t  s [8];
      word_t w [5];
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mbits.delete();
      exp_q.delete();
      mfill  = 0;
      mflush = 0;
      mcnt   = 0;
   endtask

   task automatic move_word();
      word_t w;
      for (int i = 0; i < WORD_W; i++) w[i] = mbits.pop_front();
      exp_q.push_back(w);
   endtask

   // One clock: drive inputs after the falling edge, observe, update model, wait for next falling edge.
   task automatic step(input logic v, input sym_t d, input logic wr, input logic fl);
      bus.sym_valid  = v;
      bus.sym_data   = d;
      bus.word_ready = wr;
      bus.flush      = fl;
      #1;
      obs_push  = bus.sym_valid & bus.sym_ready;
      obs_pop   = bus.word_valid & bus.word_ready;
      obs_busy  = bus.busy;
      obs_valid = bus.word_valid;
      obs_phase = bus.word_phase;
      obs_data  = bus.word_data;
      if (chk_en) begin
         if (mflush && !obs_busy) begin
            mflush = 0;
            mcnt   = 0;
         end
         chk("word_valid_rule", obs_valid, (mfill >= 16) || (mflush && mfill != 0));
         chk("sym_ready_rule", bus.sym_ready, !mflush && (mfill <= 15 || obs_pop));
         if (obs_pop) begin
            got_q.push_back(obs_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h, none expected", obs_data);
            end else begin
               chk("word_data", obs_data, exp_q.pop_front());
               chk("word_phase", obs_phase, mcnt % GROUP_WORDS);
            end
            mcnt++;
            mfill = (mfill >= 16) ? mfill - 16 : 0;
         end
         if (obs_push) begin
            for (int i = 0; i < SYM_W; i++) mbits.push_back(d[i]);
            mfill += SYM_W;
         end
         while (mbits.size() >= WORD_W) move_word();
         if (fl && !mflush) begin
            if (mbits.size() > 0) begin
               while (mbits.size() < WORD_W) mbits.push_back(1'b0);
               move_word();
            end
            mflush = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      chk_en = 0;
      rst    = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      model_clear();
      got_q.delete();
      chk_en = 1;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      step(1'b0, '0, 1'b1, 1'b0);
      while ((obs_busy || exp_q.size() != 0) && n < 200) begin
         step(1'b0, '0, 1'b1, 1'b0);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles", nm, obs_busy, exp_q.size(), n);
      end
   endtask

   initial begin
      int acc_cnt;
      int n;

      bus.sym_valid  = 1'b0;
      bus.sym_data   = '0;
      bus.word_ready = 1'b0;
      bus.flush      = 1'b0;
      chk_en         = 0;
      model_clear();

      tbl[0].s = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
      tbl[0].w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      tbl[1].s = '{10'h155, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
      tbl[1].w = '{16'h0155, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      tbl[2].s = '{10'h000, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
      tbl[2].w = '{16'hFC00, 16'h000F, 16'h0000, 16'h0000, 16'h0000};
      tbl[3].s = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF};
      tbl[3].w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFC0};

      @(negedge clk);
      do_reset();
      #1;
      chk("rst_word_valid", bus.word_valid, 1'b0);
      chk("rst_word_data", bus.word_data, 16'h0000);
      chk("rst_sym_ready", bus.sym_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_phase", bus.word_phase, 3'd0);
      @(negedge clk);

      // Table vectors: one full group each, downstream always ready.
      for (int t = 0; t < 4; t++) begin
         do_reset();
         for (int k = 0; k < GROUP_SYMS; k++) begin
            step(1'b1, tbl[t].s[k], 1'b1, 1'b0);
            chk("tbl_accept", obs_push, 1'b1);
         end
         drain("tbl");
         chk("tbl_word_count", got_q.size(), GROUP_WORDS);
         for (int j = 0; j < GROUP_WORDS && j < got_q.size(); j++)
            chk($sformatf("tbl%0d_word%0d", t, j), got_q[j], tbl[t].w[j]);
         chk("tbl_end_phase", obs_phase, 3'd0);
         chk("tbl_end_busy", obs_busy, 1'b0);
      end

      // Downstream stalled: only two symbols fit, first word held.
      do_reset();
      acc_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 10'h3FF, 1'b0, 1'b0);
         if (obs_push) acc_cnt++;
      end
      chk("stall_accepts", acc_cnt, 2);
      chk("stall_held_data", obs_data, 16'hFFFF);
      chk("stall_valid", obs_valid, 1'b1);
      n = 0;
      while (acc_cnt < GROUP_SYMS && n < 50) begin
         step(1'b1, 10'h3FF, 1'b1, 1'b0);
         if (obs_push) acc_cnt++;
         n++;
      end
      chk("resume_accepts", acc_cnt, GROUP_SYMS);
      drain("stall");
      chk("stall_word_count", got_q.size(), GROUP_WORDS);

      // Single symbol then flush: one padded word, group phase restarts.
      do_reset();
      step(1'b1, 10'h2AA, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("flush_no_pop_yet", obs_pop, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush_pop", obs_pop, 1'b1);
      chk("flush_word", obs_data, 16'h02AA);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush_busy_clear", obs_busy, 1'b0);
      chk("flush_phase", obs_phase, 3'd0);
      // Flush with nothing buffered: pending for one cycle, no word.
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 10'h111, 1'b1, 1'b0);
      chk("flush0_busy", obs_busy, 1'b1);
      chk("flush0_no_word", obs_valid, 1'b0);
      chk("flush0_blocks_sym", obs_push, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush0_done", obs_busy, 1'b0);
      chk("flush0_word_count", got_q.size(), 1);

      // Reset mid-group discards buffered bits.
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 10'h3FF, 1'b0, 1'b0);
      chk_en = 0;
      rst    = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      model_clear();
      got_q.delete();
      chk_en = 1;
      #1;
      chk("midrst_word_valid", bus.word_valid, 1'b0);
      chk("midrst_sym_ready", bus.sym_ready, 1'b1);
      chk("midrst_busy", bus.busy, 1'b0);
      @(negedge clk);
      for (int k = 0; k < GROUP_SYMS; k++) step(1'b1, sym_t'($urandom), 1'b1, 1'b0);
      drain("midrst");
      chk("midrst_word_count", got_q.size(), GROUP_WORDS);

      // Random traffic with back-pressure and occasional flushes.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         step(($urandom % 4) != 0, sym_t'($urandom), ($urandom % 4) != 0,
              ($urandom % 64) == 0);
      end
      step(1'b0, '0, 1'b1, 1'b1);
      drain("rand");
      chk("rand_model_empty", exp_q.size(), 0);
      chk("rand_end_phase", obs_phase, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
